// File: rtl/alu_job_pkg.sv
// Shared definitions for the ALU job loader and the ALU control FSM.
// Record layout offsets and loader state encoding live here.
package alu_job_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int OP_W   = 5;
  localparam int STRIDE = 4;

  localparam int OFF_A   = 0;
  localparam int OFF_B   = 1;
  localparam int OFF_OP  = 2;
  localparam int OFF_RES = 3;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_WR_A,
    LD_WR_B,
    LD_WR_OP,
    LD_DONE
  } ld_state_e;

endpackage

// File: rtl/alu_job_loader.sv
// Streams ALU jobs into shared RAM as fixed-stride records (a, b, op).
// The result slot of each record is left for the control FSM.
module alu_job_loader #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int OP_W      = 5,
  parameter int BASE_ADDR = 0,
  parameter int STRIDE    = 4,
  parameter int MAX_JOBS  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [OP_W-1:0]   in_op,
  input  logic              in_last,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] job_count
);

  import alu_job_pkg::*;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] O_A  = ADDR_W'(OFF_A);
  localparam logic [ADDR_W-1:0] O_B  = ADDR_W'(OFF_B);
  localparam logic [ADDR_W-1:0] O_OP = ADDR_W'(OFF_OP);
  localparam logic [ADDR_W:0]   MAXN = (ADDR_W+1)'(MAX_JOBS);

  ld_state_e         state;
  logic [DATA_W-1:0] buf_b;
  logic [OP_W-1:0]   buf_op;
  logic              buf_last;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   count_nx;
  logic              accept;

  assign in_ready = (state == LD_IDLE) && !start;
  assign accept   = in_valid && in_ready;
  assign count_nx = {1'b0, job_count} + 1'b1;

  // Operand a goes straight to the write register on the accept edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LD_IDLE;
      ptr       <= BASE;
      job_count <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      w_en      <= 1'b0;
      w_addr    <= '0;
      w_data    <= '0;
      buf_b     <= '0;
      buf_op    <= '0;
      buf_last  <= 1'b0;
    end else begin
      unique case (state)
        LD_IDLE: begin
          if (start) begin
            ptr       <= BASE;
            job_count <= '0;
            done      <= 1'b0;
          end else if (accept) begin
            buf_b    <= in_b;
            buf_op   <= in_op;
            buf_last <= in_last;
            w_en     <= 1'b1;
            w_addr   <= ptr + O_A;
            w_data   <= in_a;
            busy     <= 1'b1;
            state    <= LD_WR_A;
          end
        end
        LD_WR_A: begin
          w_addr <= ptr + O_B;
          w_data <= buf_b;
          state  <= LD_WR_B;
        end
        LD_WR_B: begin
          w_addr <= ptr + O_OP;
          w_data <= DATA_W'(buf_op);
          state  <= LD_WR_OP;
        end
        LD_WR_OP: begin
          w_en      <= 1'b0;
          busy      <= 1'b0;
          ptr       <= ptr + STEP;
          job_count <= job_count + 1'b1;
          if (buf_last || count_nx == MAXN) begin
            done  <= 1'b1;
            state <= LD_DONE;
          end else begin
            state <= LD_IDLE;
          end
        end
        LD_DONE: begin
          if (start) begin
            ptr       <= BASE;
            job_count <= '0;
            done      <= 1'b0;
            state     <= LD_IDLE;
          end
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_job_loader.sv
// Directed bench for alu_job_loader: default, MAX_JOBS=2 and
// BASE_ADDR=252 instances share one input stream.
module tb_alu_job_loader;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int OW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [OW-1:0] in_op = '0;

  logic          rdy    [3];
  logic          w_en   [3];
  logic [AW-1:0] w_addr [3];
  logic [DW-1:0] w_data [3];
  logic          busy   [3];
  logic          done   [3];
  logic [AW-1:0] cnt    [3];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [DW-1:0] mem [256];
  int wcnt [256];
  int nwr = 0;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [OW-1:0] op;
    logic          last;
    int            base;
  } vec_t;

  vec_t vecs [3];
  int   acc  [3];

  always #5 clk = ~clk;

  alu_job_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(rdy[0]),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
    .w_en(w_en[0]), .w_addr(w_addr[0]), .w_data(w_data[0]),
    .busy(busy[0]), .done(done[0]), .job_count(cnt[0])
  );

  alu_job_loader #(.MAX_JOBS(2)) dut_max2 (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(rdy[1]),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
    .w_en(w_en[1]), .w_addr(w_addr[1]), .w_data(w_data[1]),
    .busy(busy[1]), .done(done[1]), .job_count(cnt[1])
  );

  alu_job_loader #(.BASE_ADDR(252)) dut_wrap (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(rdy[2]),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
    .w_en(w_en[2]), .w_addr(w_addr[2]), .w_data(w_data[2]),
    .busy(busy[2]), .done(done[2]), .job_count(cnt[2])
  );

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // RAM model of the default instance, updated at each falling edge
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (w_en[0]) begin
      mem[w_addr[0]] = w_data[0];
      wcnt[w_addr[0]]++;
      nwr++;
    end
  endtask

  task automatic clear_log();
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      wcnt[i] = 0;
    end
    nwr = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_a = '0;
    in_b = '0;
    in_op = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
  endtask

  task automatic wait_ready(input int which);
    int n;
    n = 0;
    #1;
    while (!rdy[which] && n < 40) begin
      tick();
      #1;
      n++;
    end
    if (n >= 40) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got waited %0d cycles required < 40", n);
    end
  endtask

  task automatic offer(input int which, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [OW-1:0] op,
                       input logic last);
    in_a = a;
    in_b = b;
    in_op = op;
    in_last = last;
    in_valid = 1'b1;
    wait_ready(which);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_wr(input string name, input int which,
                        input int addr, input logic [DW-1:0] data);
    chk({name, "_en"}, w_en[which], 1);
    chk({name, "_addr"}, w_addr[which], addr);
    chk({name, "_data"}, w_data[which], data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{a: 32'h0000_0011, b: 32'h0000_0022, op: 5'd4,
                last: 1'b0, base: 0};
    vecs[1] = '{a: 32'hDEAD_BEEF, b: 32'h1234_5678, op: 5'd31,
                last: 1'b0, base: 4};
    vecs[2] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0000, op: 5'd0,
                last: 1'b1, base: 8};

    // 1: reset values, then a single job
    do_reset();
    chk("rst_w_en", w_en[0], 0);
    chk("rst_w_addr", w_addr[0], 0);
    chk("rst_w_data", w_data[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_count", cnt[0], 0);
    chk("rst_ready", rdy[0], 1);
    pulse_start();
    offer(0, 32'd5, 32'd3, 5'd1, 1'b1);
    chk_wr("t1_a", 0, 0, 32'd5);
    chk("t1_busy", busy[0], 1);
    tick();
    chk_wr("t1_b", 0, 1, 32'd3);
    tick();
    chk_wr("t1_op", 0, 2, 32'd1);
    tick();
    chk("t1_w_en_off", w_en[0], 0);
    chk("t1_done", done[0], 1);
    chk("t1_count", cnt[0], 1);
    chk("t1_busy_off", busy[0], 0);
    chk("t1_ready", rdy[0], 0);

    // 2: back-to-back jobs with in_valid held
    do_reset();
    pulse_start();
    clear_log();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = vecs[i].a;
      in_b = vecs[i].b;
      in_op = vecs[i].op;
      in_last = vecs[i].last;
      wait_ready(0);
      acc[i] = cyc;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_a%0d", i), mem[vecs[i].base], vecs[i].a);
      chk($sformatf("t2_b%0d", i), mem[vecs[i].base + 1], vecs[i].b);
      chk($sformatf("t2_op%0d", i), mem[vecs[i].base + 2],
          {27'd0, vecs[i].op});
      chk($sformatf("t2_res%0d", i), wcnt[vecs[i].base + 3], 0);
      if (i > 0)
        chk($sformatf("t2_gap%0d", i), acc[i] - acc[i-1], 4);
    end
    chk("t2_nwr", nwr, 9);
    chk("t2_done", done[0], 1);
    chk("t2_count", cnt[0], 3);

    // 3: MAX_JOBS=2 without last; third offer stalls until start
    do_reset();
    pulse_start();
    in_a = 32'hA5;
    in_b = 32'h5A;
    in_op = 5'd9;
    in_last = 1'b0;
    in_valid = 1'b1;
    begin
      int n_acc;
      n_acc = 0;
      for (int i = 0; i < 24; i++) begin
        #1;
        if (rdy[1]) n_acc++;
        tick();
      end
      chk("t3_accepts", n_acc, 2);
    end
    chk("t3_done", done[1], 1);
    chk("t3_ready", rdy[1], 0);
    chk("t3_count", cnt[1], 2);
    start = 1'b1;
    #1;
    chk("t3_start_ready", rdy[1], 0);
    tick();
    start = 1'b0;
    #1;
    chk("t3_restart_done", done[1], 0);
    chk("t3_restart_count", cnt[1], 0);
    chk("t3_no_accept", busy[1], 0);
    chk("t3_ready_again", rdy[1], 1);
    tick();
    in_valid = 1'b0;
    chk_wr("t3_third", 1, 0, 32'hA5);

    // 4: async reset in WR_B
    do_reset();
    offer(0, 32'hAA, 32'hBB, 5'd7, 1'b1);
    tick();
    chk("t4_in_wr_b", w_addr[0], 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t4_w_en", w_en[0], 0);
    chk("t4_w_addr", w_addr[0], 0);
    chk("t4_w_data", w_data[0], 0);
    chk("t4_busy", busy[0], 0);
    clear_log();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_no_writes", nwr, 0);
    offer(0, 32'h77, 32'h66, 5'd3, 1'b1);
    chk_wr("t4_a", 0, 0, 32'h77);
    tick();
    chk_wr("t4_b", 0, 1, 32'h66);
    tick();
    chk_wr("t4_op", 0, 2, 32'h3);

    // 5: start vs in_valid in IDLE, start during WR_A
    do_reset();
    start = 1'b1;
    in_a = 32'h99;
    in_valid = 1'b1;
    #1;
    chk("t5_ready_start", rdy[0], 0);
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    chk("t5_no_busy", busy[0], 0);
    chk("t5_no_write", w_en[0], 0);
    offer(0, 32'd9, 32'd8, 5'd2, 1'b0);
    chk_wr("t5_a", 0, 0, 32'd9);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_wr("t5_b", 0, 1, 32'd8);
    tick();
    chk_wr("t5_op", 0, 2, 32'd2);
    tick();
    chk("t5_count", cnt[0], 1);
    chk("t5_done", done[0], 0);
    chk("t5_ready", rdy[0], 1);

    // 6: BASE_ADDR=252 wraps on the second record
    do_reset();
    pulse_start();
    offer(2, 32'd1, 32'd2, 5'd3, 1'b0);
    chk_wr("t6_r0a", 2, 252, 32'd1);
    tick();
    chk_wr("t6_r0b", 2, 253, 32'd2);
    tick();
    chk_wr("t6_r0op", 2, 254, 32'd3);
    tick();
    offer(2, 32'd4, 32'd5, 5'd6, 1'b1);
    chk_wr("t6_r1a", 2, 0, 32'd4);
    tick();
    chk_wr("t6_r1b", 2, 1, 32'd5);
    tick();
    chk_wr("t6_r1op", 2, 2, 32'd6);
    tick();
    chk("t6_done", done[2], 1);
    chk("t6_count", cnt[2], 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
